// File: rtl/sd_write_snapshot.sv
// sd_write_snapshot: write-side sector sequencer. Copies a frame-buffer region
// into a fixed SD slot, one 512-byte sector per SD write command.
// Optional feature macro: SD_WR_TIMEOUT_EN adds a WAIT-state watchdog that
// aborts the snapshot with err set when the controller never drops wr_busy.
//
// state | meaning
// IDLE  | waiting for snap_req; slot address latched on accept
// ISSUE | one cycle; wr_start_en registered out for the current sector
// WAIT  | controller pulling words; leave on falling edge of wr_busy
// DONE  | one cycle; done pulse registered out, then back to IDLE
module sd_write_snapshot #(
  parameter logic [31:0] BASE_SEC      = 32'd28000,
  parameter logic [31:0] SLOT_SECS     = 32'd1200,
  parameter logic [10:0] SEC_NUM       = 11'd1200,
  parameter logic [8:0]  WORDS_PER_SEC = 9'd256,
  parameter int          ADDR_W        = 19,
  parameter logic [23:0] TIMEOUT_CYC   = 24'd5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              snap_req,
  input  logic [1:0]        snap_slot,
  input  logic              wr_busy,
  input  logic              wr_req,
  input  logic [15:0]       src_data,
  output logic              wr_start_en,
  output logic [31:0]       wr_sec_addr,
  output logic [15:0]       wr_data,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic        busy_d0, busy_d1;
  logic        busy_fall;
  logic [10:0] sec_cnt;
  logic [8:0]  word_cnt;
  logic [8:0]  word_cnt_nxt;
  logic        word_take;
  logic        last_sec;
  logic        wdog_fire;

  assign busy_fall    = busy_d1 & ~busy_d0;
  assign word_take    = wr_req & (state == WAIT);
  // The word arriving in the same cycle as the busy-fall detect still counts.
  assign word_cnt_nxt = word_cnt + {8'd0, word_take};
  assign last_sec     = (sec_cnt == SEC_NUM - 11'd1);

  assign busy      = (state != IDLE);
  assign src_rd_en = wr_req & busy;
  assign wr_data   = src_data;

`ifdef SD_WR_TIMEOUT_EN
  logic [23:0] wdog;

  // Watchdog down-counter: loaded on ISSUE, runs down through WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog <= '0;
    end else if (state == ISSUE) begin
      wdog <= TIMEOUT_CYC - 24'd1;
    end else if (state == WAIT && wdog != 24'd0) begin
      wdog <= wdog - 24'd1;
    end
  end

  // A real busy fall in the terminal cycle wins over the timeout.
  assign wdog_fire = (state == WAIT) && (wdog == 24'd0) && !busy_fall;
`else
  assign wdog_fire = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (snap_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (wdog_fire)      state_nxt = IDLE;
        else if (busy_fall) state_nxt = last_sec ? DONE : ISSUE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sector/word bookkeeping, busy edge detect and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_d0     <= 1'b0;
      busy_d1     <= 1'b0;
      wr_start_en <= 1'b0;
      done        <= 1'b0;
      wr_sec_addr <= '0;
      sec_cnt     <= '0;
      word_cnt    <= '0;
      src_addr    <= '0;
      err         <= 1'b0;
    end else begin
      busy_d0     <= wr_busy;
      busy_d1     <= busy_d0;
      wr_start_en <= (state == ISSUE);
      done        <= (state == DONE);

      if (word_take) src_addr <= src_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

      case (state)
        IDLE: begin
          if (snap_req) begin
            wr_sec_addr <= BASE_SEC + 32'(snap_slot) * SLOT_SECS;
            sec_cnt     <= '0;
            word_cnt    <= '0;
            src_addr    <= '0;
            err         <= 1'b0;
          end
        end
        WAIT: begin
          if (wdog_fire) begin
            err <= 1'b1;
          end else if (busy_fall) begin
            if (word_cnt_nxt != WORDS_PER_SEC) err <= 1'b1;
            word_cnt <= '0;
            if (!last_sec) begin
              sec_cnt     <= sec_cnt + 11'd1;
              wr_sec_addr <= wr_sec_addr + 32'd1;
            end
          end else begin
            word_cnt <= word_cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_write_snapshot.sv
// tb_sd_write_snapshot: directed bench for sd_write_snapshot with SEC_NUM=2.
// A frame-buffer model returns data = address; expected wr_data words are
// queued as wr_req is driven and compared when the word appears.
module tb_sd_write_snapshot;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        snap_req = 1'b0;
  logic [1:0]  snap_slot = 2'd0;
  logic        wr_busy = 1'b0;
  logic        wr_req = 1'b0;
  logic [15:0] src_data = 16'd0;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic [15:0] wr_data;
  logic        src_rd_en;
  logic [18:0] src_addr;
  logic        busy;
  logic        done;
  logic        err;

  int          vectors = 0;
  int          miscompares = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;
  int          start_base;
  int          done_base;
  logic [31:0] exp_addr = 32'd0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  sd_write_snapshot #(
    .SEC_NUM     (11'd2),
    .TIMEOUT_CYC (24'd1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .snap_req    (snap_req),
    .snap_slot   (snap_slot),
    .wr_busy     (wr_busy),
    .wr_req      (wr_req),
    .src_data    (src_data),
    .wr_start_en (wr_start_en),
    .wr_sec_addr (wr_sec_addr),
    .wr_data     (wr_data),
    .src_rd_en   (src_rd_en),
    .src_addr    (src_addr),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // Frame buffer: one-cycle read latency, contents equal to the word address.
  always @(posedge clk) if (src_rd_en) src_data <= src_addr[15:0];

  // Strobe counters.
  always @(posedge clk) begin
    if (wr_start_en) start_cnt <= start_cnt + 1;
    if (done)        done_cnt  <= done_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_snap(input logic [1:0] slot);
    snap_slot = slot;
    snap_req  = 1'b1;
    tick;
    snap_req  = 1'b0;
    exp_addr  = 32'd0;
    check("accept_busy", {31'd0, busy}, 32'd1);
    check("accept_err_clear", {31'd0, err}, 32'd0);
    check("accept_src_addr", {13'd0, src_addr}, 32'd0);
    check("start_lat_early", {31'd0, wr_start_en}, 32'd0);
    tick;
    check("start_lat", {31'd0, wr_start_en}, 32'd1);
  endtask

  task automatic wait_start(input logic [31:0] exp_sec);
    int n = 0;
    while (wr_start_en !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("start_seen", {31'd0, wr_start_en}, 32'd1);
    check("sec_addr", wr_sec_addr, exp_sec);
    tick;
    check("start_width", {31'd0, wr_start_en}, 32'd0);
  endtask

  task automatic push_word;
    wr_req = 1'b1;
    #1;
    check("rd_en", {31'd0, src_rd_en}, 32'd1);
    sb_q.push_back(exp_addr[15:0]);
    exp_addr = exp_addr + 32'd1;
    tick;
    wr_req = 1'b0;
    check("wr_data", {16'd0, wr_data}, {16'd0, sb_q.pop_front()});
  endtask

  task automatic sector(input int nwords, input bit poke);
    wr_busy = 1'b1;
    if (poke) begin
      snap_slot = 2'd3;
      snap_req  = 1'b1;
      tick;
      snap_req  = 1'b0;
      check("poke_busy", {31'd0, busy}, 32'd1);
    end else begin
      tick;
    end
    for (int i = 0; i < nwords; i++) push_word();
    check("src_addr_sector", {13'd0, src_addr}, exp_addr);
    wr_busy = 1'b0;
    tick;
  endtask

  task automatic wait_done(input logic [31:0] exp_sec);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_last_sec", wr_sec_addr, exp_sec);
    tick;
    check("done_width", {31'd0, done}, 32'd0);
  endtask

  initial begin
    // Reset
    repeat (3) tick;
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_start", {31'd0, wr_start_en}, 32'd0);
    check("rst_sec_addr", wr_sec_addr, 32'd0);
    check("rst_src_addr", {13'd0, src_addr}, 32'd0);

    // Clean two-sector snapshot into slot 1
    start_base = start_cnt;
    done_base  = done_cnt;
    start_snap(2'd1);
    wait_start(32'd29200);
    sector(256, 1'b0);
    wait_start(32'd29201);
    sector(256, 1'b0);
    wait_done(32'd29201);
    check("t1_err", {31'd0, err}, 32'd0);
    check("t1_src_addr_end", {13'd0, src_addr}, 32'd512);
    check("t1_starts", start_cnt - start_base, 32'd2);
    check("t1_dones", done_cnt - done_base, 32'd1);

    // Short first sector sets err; snap_req during WAIT is ignored
    start_base = start_cnt;
    done_base  = done_cnt;
    start_snap(2'd1);
    wait_start(32'd29200);
    sector(255, 1'b0);
    wait_start(32'd29201);
    check("t2_err_set", {31'd0, err}, 32'd1);
    sector(256, 1'b1);
    wait_done(32'd29201);
    check("t2_err_sticky", {31'd0, err}, 32'd1);
    check("t2_src_addr_end", {13'd0, src_addr}, 32'd511);
    check("t2_starts", start_cnt - start_base, 32'd2);
    check("t2_dones", done_cnt - done_base, 32'd1);
    repeat (5) tick;
    check("t2_idle_after_poke", {31'd0, busy}, 32'd0);

    // Reset 100 words into sector 1, then restart into slot 2
    start_snap(2'd1);
    check("t3_err_cleared", {31'd0, err}, 32'd0);
    wait_start(32'd29200);
    sector(256, 1'b0);
    wait_start(32'd29201);
    wr_busy = 1'b1;
    tick;
    for (int i = 0; i < 100; i++) push_word();
    rst = 1'b1;
    tick;
    rst = 1'b0;
    wr_busy = 1'b0;
    check("t3_rst_busy", {31'd0, busy}, 32'd0);
    check("t3_rst_sec_addr", wr_sec_addr, 32'd0);
    check("t3_rst_src_addr", {13'd0, src_addr}, 32'd0);
    check("t3_rst_start", {31'd0, wr_start_en}, 32'd0);
    check("t3_rst_done", {31'd0, done}, 32'd0);
    start_base = start_cnt;
    done_base  = done_cnt;
    repeat (4) tick;
    check("t3_no_resume", start_cnt - start_base, 32'd0);
    start_snap(2'd2);
    wait_start(32'd30400);
    sector(256, 1'b0);
    wait_start(32'd30401);
    sector(256, 1'b0);
    wait_done(32'd30401);
    check("t3_err", {31'd0, err}, 32'd0);
    check("t3_src_addr_end", {13'd0, src_addr}, 32'd512);
    check("t3_dones", done_cnt - done_base, 32'd1);

    // Controller stuck busy
    done_base = done_cnt;
    start_snap(2'd0);
    wait_start(32'd28000);
    wr_busy = 1'b1;
`ifdef SD_WR_TIMEOUT_EN
    repeat (998) tick;
    check("t4_busy_before_timeout", {31'd0, busy}, 32'd1);
    tick;
    check("t4_busy_after_timeout", {31'd0, busy}, 32'd0);
    check("t4_err_timeout", {31'd0, err}, 32'd1);
    repeat (3) tick;
    check("t4_no_done", done_cnt - done_base, 32'd0);
`else
    repeat (1100) tick;
    check("t4_busy_holds", {31'd0, busy}, 32'd1);
    check("t4_err_clear", {31'd0, err}, 32'd0);
    check("t4_no_done", done_cnt - done_base, 32'd0);
`endif
    wr_busy = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t4_final_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
